// File: rtl/fetch_unit.sv
// Instruction fetch front end: credit-limited request issue, in-order response
// pairing with request PCs, a circular instruction buffer and redirect flushing.
module fetch_unit #(
  parameter int               XLEN     = 32,
  parameter int               DEPTH    = 4,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  output logic             o_IM_req,
  output logic [XLEN-1:0]  o_IM_addr,
  input  logic             i_IM_ack,
  input  logic             i_IM_rvalid,
  input  logic [31:0]      i_IM_rdata,
  output logic             o_valid,
  output logic [31:0]      o_instr,
  output logic [XLEN-1:0]  o_pc,
  input  logic             i_ready,
  input  logic             i_redirect,
  input  logic [XLEN-1:0]  i_redirect_pc
);

  localparam int              CW      = $clog2(DEPTH + 1);
  localparam int              PW      = $clog2(DEPTH);
  localparam logic [CW:0]     CREDITS = (CW + 1)'(DEPTH);
  localparam logic [PW-1:0]   LAST    = PW'(DEPTH - 1);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  logic            started;
  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0]   outstanding, outstanding_nxt, discard_count, buf_count;
  logic [PW-1:0]   buf_wr, buf_rd, pq_wr, pq_rd;
  logic [31:0]     buf_instr [DEPTH];
  logic [XLEN-1:0] buf_pc    [DEPTH];
  logic [XLEN-1:0] pq_pc     [DEPTH];
  logic            accept, resp, push, pop;

  // Credit check is done one bit wider so the sum can never wrap.
  assign o_IM_req  = started && (({1'b0, outstanding} + {1'b0, buf_count}) < CREDITS);
  assign o_IM_addr = fetch_pc;

  assign accept = o_IM_req && i_IM_ack;
  assign resp   = i_IM_rvalid && (outstanding != '0);
  assign push   = resp && !i_redirect && (discard_count == '0);
  assign pop    = o_valid && i_ready && !i_redirect;

  assign outstanding_nxt = outstanding + CW'(accept) - CW'(resp);

  assign o_valid = (buf_count != '0);
  assign o_instr = o_valid ? buf_instr[buf_rd] : '0;
  assign o_pc    = o_valid ? buf_pc[buf_rd]    : '0;

  // Payload storage needs no reset; it is only visible while o_valid is high.
  always_ff @(posedge i_clk) begin
    if (accept) pq_pc[pq_wr] <= fetch_pc;
    if (push) begin
      buf_instr[buf_wr] <= i_IM_rdata;
      buf_pc[buf_wr]    <= pq_pc[pq_rd];
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      started       <= 1'b0;
      fetch_pc      <= RESET_PC;
      outstanding   <= '0;
      discard_count <= '0;
      buf_count     <= '0;
      buf_wr        <= '0;
      buf_rd        <= '0;
      pq_wr         <= '0;
      pq_rd         <= '0;
    end else begin
      started     <= 1'b1;
      outstanding <= outstanding_nxt;
      if (accept) pq_wr <= ptr_inc(pq_wr);
      if (resp)   pq_rd <= ptr_inc(pq_rd);
      if (i_redirect) begin
        // Everything still in flight after this edge belongs to the old stream.
        fetch_pc      <= i_redirect_pc & ~XLEN'(3);
        discard_count <= outstanding_nxt;
        buf_count     <= '0;
        buf_wr        <= '0;
        buf_rd        <= '0;
      end else begin
        if (accept) fetch_pc <= fetch_pc + XLEN'(4);
        if (resp && (discard_count != '0)) discard_count <= discard_count - 1'b1;
        if (push) buf_wr <= ptr_inc(buf_wr);
        if (pop)  buf_rd <= ptr_inc(buf_rd);
        if (push && !pop)      buf_count <= buf_count + 1'b1;
        else if (pop && !push) buf_count <= buf_count - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, backpressure, redirects, PC wrap
// and reset with responses in flight.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rstn, ack, rvalid, ready, redirect;
  logic [31:0] rdata, redirect_pc;
  logic        req, valid;
  logic [31:0] addr, instr, pc;

  logic        w_req, w_valid;
  logic [31:0] w_addr, w_instr, w_pc;

  int checks   = 0;
  int failures = 0;
  int n_acc    = 0;

  logic [31:0] mq[$];
  logic [31:0] pops[$];
  logic [31:0] pop_instr[$];
  bit          auto_resp = 1'b0;
  bit          stray     = 1'b0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .i_clk(clk), .i_rstn(rstn),
    .o_IM_req(req), .o_IM_addr(addr), .i_IM_ack(ack),
    .i_IM_rvalid(rvalid), .i_IM_rdata(rdata),
    .o_valid(valid), .o_instr(instr), .o_pc(pc),
    .i_ready(ready), .i_redirect(redirect), .i_redirect_pc(redirect_pc)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .i_clk(clk), .i_rstn(rstn),
    .o_IM_req(w_req), .o_IM_addr(w_addr), .i_IM_ack(1'b1),
    .i_IM_rvalid(1'b0), .i_IM_rdata(32'h0),
    .o_valid(w_valid), .o_instr(w_instr), .o_pc(w_pc),
    .i_ready(1'b0), .i_redirect(1'b0), .i_redirect_pc(32'h0)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [31:0] pop_at(input int i);
    return (i < pops.size()) ? pops[i] : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] instr_at(input int i);
    return (i < pop_instr.size()) ? pop_instr[i] : 32'hFFFF_FFFF;
  endfunction

  // Memory model answers one cycle after acceptance, in order; inputs are
  // set and outputs sampled 1 time unit after each rising edge.
  task automatic tick();
    if (stray) begin
      rvalid = 1'b1;
      rdata  = 32'hDEAD_0000;
    end else if (auto_resp && mq.size() > 0) begin
      rdata  = mk(mq.pop_front());
      rvalid = 1'b1;
    end else begin
      rvalid = 1'b0;
      rdata  = '0;
    end
    if (req && ack) begin
      mq.push_back(addr);
      n_acc++;
    end
    if (valid && ready && !redirect) begin
      pops.push_back(pc);
      pop_instr.push_back(instr);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rstn = 1'b0; ack = 1'b0; rvalid = 1'b0; rdata = '0;
    ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    ticks(3);
    check_eq("rst_req",   req,   1'b0);
    check_eq("rst_valid", valid, 1'b0);
    check_eq("rst_instr", instr, 32'h0);
    check_eq("rst_pc",    pc,    32'h0);
    check_eq("rst_addr",  addr,  32'h0);
    check_eq("rst_waddr", w_addr, 32'hFFFF_FFFC);

    // Release, then streaming.
    rstn = 1'b1;
    check_eq("rel_req_low", req, 1'b0);
    ack = 1'b1; ready = 1'b1; auto_resp = 1'b1;
    tick();
    check_eq("first_req",  req,    1'b1);
    check_eq("w_first",    w_addr, 32'hFFFF_FFFC);
    tick();
    check_eq("w_wrap",     w_addr, 32'h0);
    ticks(10);
    check_eq("stream_cnt", pops.size(), 9);
    for (int i = 0; i < 9; i++) begin
      check_eq("stream_pc",    pop_at(i),   32'(4 * i));
      check_eq("stream_instr", instr_at(i), mk(32'(4 * i)));
    end

    // Backpressure.
    ready = 1'b0; n_acc = 0;
    check_eq("bp_head0", pc, 32'd36);
    ticks(10);
    check_eq("bp_acc",   n_acc, 2);
    check_eq("bp_req",   req,   1'b0);
    check_eq("bp_valid", valid, 1'b1);
    check_eq("bp_hold",  pc,    32'd36);
    check_eq("bp_instr", instr, mk(32'd36));
    pops.delete(); pop_instr.delete();
    ready = 1'b1;
    ticks(10);
    for (int i = 0; i < 8; i++) check_eq("bp_order", pop_at(i), 32'(36 + 4 * i));

    // Redirect with three requests outstanding.
    ack = 1'b0;
    ticks(6);
    check_eq("drained", valid, 1'b0);
    auto_resp = 1'b0; ack = 1'b1;
    ticks(3);
    ack = 1'b0;
    check_eq("out3_req", req, 1'b1);
    redirect = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    check_eq("rd1_addr",  addr,  32'h100);
    check_eq("rd1_valid", valid, 1'b0);
    pops.delete(); pop_instr.delete();
    auto_resp = 1'b1; ack = 1'b1;
    ticks(10);
    check_eq("rd1_pc0",    pop_at(0),   32'h100);
    check_eq("rd1_pc1",    pop_at(1),   32'h104);
    check_eq("rd1_instr0", instr_at(0), mk(32'h100));

    // Redirect in the same cycle as an accept and a response, misaligned target.
    check_eq("rd2_pre_valid", valid, 1'b1);
    redirect = 1'b1; redirect_pc = 32'h203;
    tick();
    redirect = 1'b0;
    check_eq("rd2_valid", valid, 1'b0);
    check_eq("rd2_addr",  addr,  32'h200);
    check_eq("rd2_req",   req,   1'b1);
    pops.delete(); pop_instr.delete();
    ticks(8);
    check_eq("rd2_pc0",    pop_at(0),   32'h200);
    check_eq("rd2_pc1",    pop_at(1),   32'h204);
    check_eq("rd2_instr0", instr_at(0), mk(32'h200));

    // Back-to-back redirects: the last target wins.
    redirect = 1'b1; redirect_pc = 32'h300;
    tick();
    redirect_pc = 32'h400;
    tick();
    redirect = 1'b0;
    check_eq("rd3_addr", addr, 32'h400);
    pops.delete(); pop_instr.delete();
    ticks(8);
    check_eq("rd3_pc0", pop_at(0), 32'h400);
    check_eq("rd3_pc1", pop_at(1), 32'h404);

    // Reset with two requests in flight, then stray responses.
    ack = 1'b0;
    ticks(6);
    auto_resp = 1'b0; ack = 1'b1;
    ticks(2);
    ack = 1'b0;
    rstn = 1'b0;
    mq.delete();
    #1;
    check_eq("mid_rst_req",   req,   1'b0);
    check_eq("mid_rst_valid", valid, 1'b0);
    check_eq("mid_rst_addr",  addr,  32'h0);
    ticks(2);
    rstn = 1'b1;
    stray = 1'b1;
    tick();
    check_eq("stray1_valid", valid, 1'b0);
    tick();
    check_eq("stray2_valid", valid, 1'b0);
    stray = 1'b0;
    tick();
    check_eq("stray3_valid", valid, 1'b0);
    check_eq("post_rst_addr", addr, 32'h0);
    pops.delete(); pop_instr.delete();
    ack = 1'b1; auto_resp = 1'b1;
    ticks(8);
    check_eq("rst_pc0",    pop_at(0),   32'h0);
    check_eq("rst_pc1",    pop_at(1),   32'h4);
    check_eq("rst_instr0", instr_at(0), mk(32'h0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter XLEN, default 32, SHALL set PC and address width in bits.
REQ-002 Parameter DEPTH, default 4, SHALL set the instruction buffer entries and the maximum in-flight requests; legal range is 2..16.
REQ-003 Parameter RESET_PC, default 0, SHALL set the fetch address after reset; its bits [1:0] are 0.
REQ-004 i_clk  in  1  single clock; all state updates on its rising edge.
REQ-005 i_rstn  in  1  asynchronous active-low reset.
REQ-006 o_IM_req  out  1  fetch request valid.
REQ-007 o_IM_addr  out  XLEN  fetch word address; bits [1:0] always 0.
REQ-008 i_IM_ack  in  1  memory accepts the request this cycle.
REQ-009 i_IM_rvalid  in  1  read data valid; responses return in request order.
REQ-010 i_IM_rdata  in  32  instruction word.
REQ-011 o_valid  out  1  buffered instruction available to decode.
REQ-012 o_instr  out  32  instruction at buffer head.
REQ-013 o_pc  out  XLEN  address of o_instr.
REQ-014 i_ready  in  1  decode consumes the head when o_valid is high.
REQ-015 i_redirect  in  1  branch/jump taken; flush and refetch.
REQ-016 i_redirect_pc  in  XLEN  new fetch address; bits [1:0] SHALL be ignored and treated as 0.

Function
REQ-017 Request accepted SHALL mean o_IM_req and i_IM_ack high on the same rising edge; fetch_pc SHALL then advance by 4, modulo 2^XLEN.
REQ-018 o_IM_addr SHALL equal fetch_pc and SHALL hold stable while o_IM_req is high and i_IM_ack is low, unless i_redirect is high.
REQ-019 o_IM_req SHALL be high only when outstanding + buffer_count < DEPTH, with both counters $clog2(DEPTH+1) bits wide; the buffer therefore never overflows.
REQ-020 Each accepted request SHALL record its PC in order, so every response is paired with its address.
REQ-021 An i_IM_rvalid with no outstanding request SHALL be ignored.
REQ-022 A response that is not marked for discard SHALL be written to the buffer; o_valid SHALL rise on the next rising edge, giving 1-cycle rvalid-to-o_valid latency.
REQ-023 The buffer SHALL be a circular FIFO whose pointers wrap from DEPTH-1 to 0.
REQ-024 The head SHALL pop when o_valid and i_ready are both high; o_instr and o_pc SHALL hold while o_valid is high and i_ready is low.
REQ-025 Simultaneous push and pop SHALL leave buffer_count unchanged, including when the buffer is full.
REQ-026 On i_redirect, the next edge SHALL:
- empty the buffer, so o_valid is 0 the next cycle;
- set fetch_pc to i_redirect_pc;
- set discard_count to outstanding, counted after this cycle's accept and rvalid.
REQ-027 i_redirect SHALL have priority over pop, push and the normal PC increment; an i_IM_rvalid in the redirect cycle SHALL be dropped, and a request accepted in the redirect cycle SHALL count as old-stream and be discarded.
REQ-028 While discard_count > 0, each i_IM_rvalid SHALL decrement discard_count and outstanding and SHALL NOT write the buffer.
REQ-029 o_IM_req MAY assert for the redirect target in the cycle after i_redirect, subject to the credit rule in REQ-019.
REQ-030 Back-to-back redirects SHALL each re-flush; the last one determines fetch_pc.

Reset
REQ-031 While i_rstn is low, the block SHALL hold:
- fetch_pc = RESET_PC;
- outstanding, discard_count, buffer_count and pointers = 0;
- o_IM_req = 0, o_valid = 0, o_instr = 0, o_pc = 0.
REQ-032 o_IM_req SHALL first assert in the cycle following the first rising edge after i_rstn is released.
REQ-033 Reset asserted mid-operation SHALL abandon all in-flight responses; responses arriving after release with outstanding = 0 SHALL be ignored per REQ-021.

Verification
REQ-034 Streaming: ack always high, rvalid 1 cycle after ack, i_ready high -> o_pc sequence 0,4,8,12,..., one instruction per cycle after warm-up.
REQ-035 Backpressure, DEPTH=4: i_ready low for 10 cycles -> at most 4 accepted requests, o_IM_req low once 4 are buffered or in flight, no loss; release -> PCs stay in order.
REQ-036 Redirect with 3 outstanding: i_redirect_pc=0x100 -> next 3 responses dropped, first o_pc after redirect = 0x100.
REQ-037 Same-cycle redirect, accept and rvalid -> the rvalid data is dropped, the accepted request is discarded later, and fetch resumes at the target.
REQ-038 Misaligned i_redirect_pc=0x203 -> o_IM_addr=0x200; RESET_PC=0xFFFFFFFC -> the second fetch address wraps to 0x0.
REQ-039 Reset asserted with 2 outstanding, then released, followed by 2 stray i_IM_rvalid pulses -> pulses ignored, o_valid stays 0 until new fetches return from RESET_PC.
